// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage sitting directly in front of the imem.
//   Holds the program counter, presents it to the imem as a byte address,
//   captures the returned instruction plus its PC+4 into the IF/ID register,
//   and selects the next PC (sequential / branch / jump / jr). Supports stall,
//   a one-bubble squash on redirect, and a sticky fetch-fault flag.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   stall              hold PC and IF/ID this cycle (pcsel ignored)
//   pcsel[1:0]         00 PC+4, 01 branch, 10 jump, 11 jr
//   branch_off[15:0]   signed word offset of the ID-stage branch
//   jump_index[25:0]   jump field of the ID-stage instruction
//   jr_target[31:0]    register value for jr
//   pc[31:0]           fetch byte address (registered, to imem)
//   instr_in           combinational imem read data for pc
//   instr_id, pc4_id   IF/ID instruction and its PC+4
//   valid_id           instr_id is real (0 = bubble)
//   fault              sticky misaligned / out-of-window fetch flag
module fetch_unit #(
  parameter int          Nloc    = 64,
  parameter int          Dbits   = 32,
  parameter logic [31:0] resetPC = 32'h0040_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       pcsel,
  input  logic [15:0]      branch_off,
  input  logic [25:0]      jump_index,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  input  logic [Dbits-1:0] instr_in,
  output logic [Dbits-1:0] instr_id,
  output logic [31:0]      pc4_id,
  output logic             valid_id,
  output logic             fault
);

  // Exclusive upper bound of the imem fetch window.
  localparam logic [31:0] PC_HI = resetPC + 32'(4 * Nloc);

  logic [31:0]      pc_q, pc_d;
  logic [Dbits-1:0] instr_id_q, instr_id_d;
  logic [31:0]      pc4_id_q, pc4_id_d;
  logic             valid_id_q, valid_id_d;
  logic             fault_q, fault_d;

  logic [31:0] pc4, br_tgt, j_tgt, jr_tgt, nxt_pc;
  logic        jr_mis, out_win;

  always_comb begin
    // Redirect targets are relative to the ID-stage instruction, not the
    // instruction currently being fetched.
    pc4    = pc_q + 32'd4;
    br_tgt = pc4_id_q + {{14{branch_off[15]}}, branch_off, 2'b00};
    j_tgt  = {pc4_id_q[31:28], jump_index, 2'b00};
    jr_tgt = {jr_target[31:2], 2'b00};

    case (pcsel)
      2'b01:   nxt_pc = br_tgt;
      2'b10:   nxt_pc = j_tgt;
      2'b11:   nxt_pc = jr_tgt;
      default: nxt_pc = pc4;
    endcase

    jr_mis  = (pcsel == 2'b11) && (jr_target[1:0] != 2'b00);
    out_win = (nxt_pc < resetPC) || (nxt_pc >= PC_HI);

    pc_d       = pc_q;
    instr_id_d = instr_id_q;
    pc4_id_d   = pc4_id_q;
    valid_id_d = valid_id_q;
    fault_d    = fault_q;

    if (!stall) begin
      pc_d     = nxt_pc;
      pc4_id_d = pc4;
      if (pcsel == 2'b00) begin
        instr_id_d = instr_in;
        valid_id_d = 1'b1;
      end else begin
        // Squash the wrong-path instruction in flight: one bubble.
        instr_id_d = '0;
        valid_id_d = 1'b0;
      end
      // Faults are flagged but fetching carries on.
      if (jr_mis || out_win) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= resetPC;
      instr_id_q <= '0;
      pc4_id_q   <= '0;
      valid_id_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_id_q <= instr_id_d;
      pc4_id_q   <= pc4_id_d;
      valid_id_q <= valid_id_d;
      fault_q    <= fault_d;
    end
  end

  assign pc       = pc_q;
  assign instr_id = instr_id_q;
  assign pc4_id   = pc4_id_q;
  assign valid_id = valid_id_q;
  assign fault    = fault_q;

endmodule
